fp_exp_add_pipe: RTL
====================

Name: fp_exp_add_pipe

Overview:
Parametrised, two-stage pipelined exponent adder for the floating-point multiplier datapath. Computes the biased product exponent exp1 + exp2 - BIAS, plus a late normalisation increment from the mantissa path. Flags overflow, underflow and zero-operand, with valid/ready backpressure on both sides. Successor to the fixed 8-bit, unpipelined exponent adder: it generalises width and bias and adds handshake, underflow and zero detection.

Parameters:
EXP_W, 8, exponent width in bits (min 3).
BIAS, (1<<(EXP_W-1))-1, exponent bias; 127 for EXP_W=8.

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  exp1/exp2 valid
in_ready  out  1  stage 1 can accept
exp1  in  EXP_W  biased exponent, operand A
exp2  in  EXP_W  biased exponent, operand B
inc_exp  in  1  normalisation increment, aligned to stage-1 to stage-2 transfer
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
exp  out  EXP_W  biased result exponent
overflow  out  1  result >= 2^EXP_W-1
underflow  out  1  result <= 0, non-zero operands
zero  out  1  an operand exponent was 0

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (resetn).
- Reset: s1_valid=0, s2_valid=0, out_valid=0, exp=0, overflow=0, underflow=0, zero=0, in_ready=1 after release.
- Handshake:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1, combinational, no combinational path from in_valid.
- Stage 1: on in_valid && in_ready, register:
  - raw = exp1 + exp2 - BIAS, signed, EXP_W+2 bits.
  - z1 = (exp1==0) || (exp2==0).
  - s1_valid = 1.
- Stage 2: on s1_valid && adv2, register:
  - fin = raw + inc_exp. inc_exp is sampled only on this edge and ignored otherwise.
  - Flags are computed from fin.
  - s2_valid = 1.
  - If !s1_valid && adv2: s2_valid = 0.
- Latency: exactly 2 clk from input acceptance to out_valid when out_ready=1. Throughput 1 result/cycle.
- Stall: while out_valid && !out_ready, exp and all flags hold stable. Stage 1 holds if full. in_ready falls the same cycle both stages are full and out_ready=0.
- Flags, evaluated at stage 2:
  - zero=1 if z1: exp=0, overflow=0, underflow=0 (zero has priority).
  - else overflow=1 if fin >= 2^EXP_W-1 (all-ones is reserved for Inf/NaN).
  - else underflow=1 if fin <= 0.
  - At most one of zero/overflow/underflow is set.
- Normal result: exp = fin[EXP_W-1:0].
- Reset mid-operation: both stages are discarded immediately, outputs go to reset values, no partial result is emitted.
- Simultaneous accept at stage 1 and drain at stage 2 in the same cycle is legal and loses no data.

Optional Feature:
FP_EXP_SAT_EN
- Defined: on overflow, exp = all-ones (2^EXP_W-1); on underflow, exp = 0.
- Undefined: exp = fin[EXP_W-1:0] (wrapped) in both cases. Flags are identical either way.

Test Plan:
1. Basic add: EXP_W=8, exp1=0x83, exp2=0x82, inc_exp=0, out_ready=1 -> 2 clk later out_valid=1, exp=0x86, all flags 0. Same with inc_exp=1 at stage transfer -> exp=0x87.
2. Overflow boundary:
   - 190+191, inc=0 -> exp=0xFE, overflow=0.
   - 190+191, inc=1 -> overflow=1; exp=0xFF with FP_EXP_SAT_EN, 0xFF wrapped without.
   - 200+200 -> overflow=1; exp=0xFF with FP_EXP_SAT_EN, 0x11 without.
3. Underflow boundary:
   - 63+64, inc=0 -> underflow=1; exp=0x00 with FP_EXP_SAT_EN, 0x00 without.
   - 63+64, inc=1 -> exp=0x01, underflow=0.
   - 50+60 -> underflow=1; exp=0x00 with FP_EXP_SAT_EN, 0xEF without.
4. Zero operand: exp1=0, exp2=0xFE -> zero=1, exp=0, overflow=0, underflow=0.
5. Backpressure: stream 4 back-to-back inputs with out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted, out_valid/exp stable during the stall, all 4 results in order once out_ready=1, none dropped or duplicated.
6. Reset mid-operation: assert resetn=0 asynchronously with both stages full -> out_valid=0, exp=0 and all flags 0 immediately; after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/fp_exp_add_pipe.sv
// Two-stage pipelined exponent adder for the FP multiplier: exp1 + exp2 - BIAS + inc_exp.
// Define FP_EXP_SAT_EN to saturate exp on overflow/underflow (default: wrapped result).
module fp_exp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int BIAS  = (1 << (EXP_W - 1)) - 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp1,
  input  logic [EXP_W-1:0] exp2,
  input  logic             inc_exp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] exp,
  output logic             overflow,
  output logic             underflow,
  output logic             zero
);

  // Two extra bits hold the carry of the sum and the sign after bias removal.
  localparam int RW = EXP_W + 2;
  localparam logic signed [RW-1:0] BIAS_S = RW'(BIAS);
  localparam logic signed [RW-1:0] MAX_S  = RW'((1 << EXP_W) - 1);
  localparam logic [EXP_W-1:0]     ALL_ONES = '1;

  logic                 s1_valid;
  logic signed [RW-1:0] s1_raw;
  logic                 s1_zero;

  logic                 adv1;
  logic                 adv2;
  logic signed [RW-1:0] raw_d;
  logic                 zero_d;
  logic signed [RW-1:0] fin;
  logic [EXP_W-1:0]     exp_d;
  logic                 ovf_d;
  logic                 unf_d;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;

  always_comb begin
    raw_d  = $signed({2'b00, exp1}) + $signed({2'b00, exp2}) - BIAS_S;
    zero_d = (exp1 == '0) || (exp2 == '0);
  end

  // inc_exp only matters on the edge that moves stage 1 into stage 2.
  always_comb begin
    fin   = s1_raw + $signed({{(RW-1){1'b0}}, inc_exp});
    exp_d = fin[EXP_W-1:0];
    ovf_d = 1'b0;
    unf_d = 1'b0;
    if (s1_zero) begin
      exp_d = '0;
    end else if (fin >= MAX_S) begin
      ovf_d = 1'b1;
`ifdef FP_EXP_SAT_EN
      exp_d = ALL_ONES;
`endif
    end else if (fin[RW-1] || (fin == '0)) begin
      unf_d = 1'b1;
`ifdef FP_EXP_SAT_EN
      exp_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      s1_raw    <= '0;
      s1_zero   <= 1'b0;
      out_valid <= 1'b0;
      exp       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_raw  <= raw_d;
          s1_zero <= zero_d;
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          exp       <= exp_d;
          overflow  <= ovf_d;
          underflow <= unf_d;
          zero      <= s1_zero;
        end
      end
    end
  end

  // Only referenced when saturation is enabled.
  logic unused_ok;
  assign unused_ok = &ALL_ONES;

endmodule
